// File: rtl/mips_mem_pkg.sv
// Shared opcode constants, FSM state encoding and decode helpers for the MIPS
// data-memory access stage.
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfword accesses need an even address, word accesses a multiple of four.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: mis = a[0];
            OP_LW, OP_SW:         mis = (a != 2'b00);
            default:              mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Byte-lane steering for the data-memory bus: store byte enables and replicated
// write data, plus extraction and sign/zero extension of load data.
module mem_lane_fmt (
    input  logic [5:0]  opcode,
    input  logic [1:0]  a,
    input  logic [31:0] rt,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    import mips_mem_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (a)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be        = 4'b0000;
        wdata     = 32'h0;
        load_data = 32'h0;
        case (opcode)
            OP_SB: begin
                be    = 4'b0001 << a;
                wdata = {4{rt[7:0]}};
            end
            OP_SH: begin
                be    = a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            OP_SW: begin
                be    = 4'b1111;
                wdata = rt;
            end
            OP_LB: begin
                be        = 4'b1111;
                load_data = {{24{byte_sel[7]}}, byte_sel};
            end
            OP_LBU: begin
                be        = 4'b1111;
                load_data = {24'h0, byte_sel};
            end
            OP_LH: begin
                be        = 4'b1111;
                load_data = {{16{half_sel[15]}}, half_sel};
            end
            OP_LHU: begin
                be        = 4'b1111;
                load_data = {16'h0, half_sel};
            end
            OP_LW: begin
                be        = 4'b1111;
                load_data = rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the multi-cycle MIPS datapath: req/ack data-memory transaction with
// upstream stall. Define MEM_ALIGN_CHECK_EN to trap misaligned accesses via align_err.
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_m,
    input  logic [31:0]       pc4_m,
    input  logic [31:0]       alu_m,
    input  logic [31:0]       rt_m,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    output logic              stall,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc4_out,
    output logic [31:0]       alu_out,
    output logic [31:0]       memdata_out,
    output logic              align_err
);
    import mips_mem_pkg::*;

    state_t      state, state_next;
    logic [31:0] rdata_q;
    logic [5:0]  opcode;
    logic        is_mem;
    logic        misaligned;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_load;

    assign opcode    = instr_m[31:26];
    assign is_mem    = is_load(opcode) || is_store(opcode);
    assign instr_out = instr_m;
    assign pc4_out   = pc4_m;
    assign alu_out   = alu_m;
    assign mem_addr  = {alu_m[ADDR_W-1:2], 2'b00};

    mem_lane_fmt u_lane_fmt (
        .opcode    (opcode),
        .a         (alu_m[1:0]),
        .rt        (rt_m),
        .rdata     (mem_rdata),
        .be        (fmt_be),
        .wdata     (fmt_wdata),
        .load_data (fmt_load)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic err_q;

    assign misaligned = is_misaligned(opcode, alu_m[1:0]);
    assign align_err  = reset && (state == S_DONE) && err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (state == S_IDLE) begin
            err_q <= is_mem && misaligned;
        end
    end
`else
    assign misaligned = 1'b0;
    assign align_err  = 1'b0;
`endif

    // rdata_q is cleared in IDLE so a trapped access shows zero data in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            rdata_q <= 32'h0;
        end else begin
            state <= state_next;
            if (state == S_REQ && mem_ack) begin
                rdata_q <= is_load(opcode) ? fmt_load : 32'h0;
            end else if (state == S_IDLE) begin
                rdata_q <= 32'h0;
            end
        end
    end

    always_comb begin
        state_next  = state;
        stall       = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        mem_wdata   = 32'h0;
        memdata_out = 32'h0;
        case (state)
            S_IDLE:  if (is_mem) state_next = misaligned ? S_DONE : S_REQ;
            S_REQ:   if (mem_ack) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        // Outputs hold their reset values for as long as reset is low.
        if (reset) begin
            case (state)
                S_IDLE: stall = is_mem;
                S_REQ: begin
                    stall     = 1'b1;
                    mem_req   = 1'b1;
                    mem_we    = is_store(opcode);
                    mem_be    = fmt_be;
                    mem_wdata = fmt_wdata;
                end
                S_DONE:  memdata_out = rdata_q;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: random instruction stream against a word-array
// reference model, a memory responder with variable ack delay, and a DONE-slot monitor.
module tb_mem_access_stage;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] instr_m = 32'h0;
    logic [31:0] pc4_m = 32'h0;
    logic [31:0] alu_m = 32'h0;
    logic [31:0] rt_m = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        stall;
    logic [31:0] instr_out;
    logic [31:0] pc4_out;
    logic [31:0] alu_out;
    logic [31:0] memdata_out;
    logic        align_err;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic [31:0] alu;
        logic [31:0] memdata;
        logic        err;
    } done_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    done_t       done_q[$];
    req_t        req_q[$];
    logic [31:0] ref_mem[16];
    logic [31:0] bus_mem[16];
    logic [5:0]  ops[12];
    int          n_checks = 0;
    int          n_fail = 0;
    int          ack_delay = 0;
    bit          stray_ack = 1'b0;
    bit          align_chk = 1'b0;

    always #5 clk = ~clk;

    mem_access_stage #(.ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_m     (instr_m),
        .pc4_m       (pc4_m),
        .alu_m       (alu_m),
        .rt_m        (rt_m),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .stall       (stall),
        .instr_out   (instr_out),
        .pc4_out     (pc4_out),
        .alu_out     (alu_out),
        .memdata_out (memdata_out),
        .align_err   (align_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic printSummary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    // Reference model: computes the bus request and final MEM/WB data from the
    // instruction semantics, then drives the instruction until the stage stops stalling.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr,
                                 input logic [31:0] rt, input int delay);
        done_t       d;
        req_t        r;
        int          a;
        int          idx;
        int          exp_stall;
        int          stall_cnt;
        bit          is_ld;
        bit          is_st;
        bit          mis;
        bit          finished;
        logic [31:0] w;
        logic [31:0] v;
        logic [31:0] mask;

        a   = int'(addr % 4);
        idx = int'((addr / 4) % 16);
        instr_m   = {op, 26'($urandom)};
        pc4_m     = $urandom;
        alu_m     = addr;
        rt_m      = rt;
        ack_delay = delay;

        is_ld = (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
        is_st = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
        mis   = 1'b0;
        if (align_chk) begin
            if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (a % 2 == 1)) mis = 1'b1;
            if ((op == OP_LW || op == OP_SW) && a != 0) mis = 1'b1;
        end

        d.instr   = instr_m;
        d.pc4     = pc4_m;
        d.alu     = addr;
        d.memdata = 32'h0;
        d.err     = mis;
        r.we      = 1'b0;
        r.addr    = addr & 32'hFFFF_FFFC;
        r.be      = 4'hF;
        r.wdata   = 32'h0;
        w         = ref_mem[idx];

        if (is_ld && !mis) begin
            case (op)
                OP_LB, OP_LBU: begin
                    v = (w >> (8 * a)) & 32'hFF;
                    if (op == OP_LB && v >= 128) v = v + 32'hFFFF_FF00;
                end
                OP_LH, OP_LHU: begin
                    v = (w >> (16 * (a / 2))) & 32'hFFFF;
                    if (op == OP_LH && v >= 32768) v = v + 32'hFFFF_0000;
                end
                default: v = w;
            endcase
            d.memdata = v;
            req_q.push_back(r);
        end

        if (is_st && !mis) begin
            r.we = 1'b1;
            case (op)
                OP_SB: begin
                    r.be    = 4'(1 << a);
                    r.wdata = (rt & 32'hFF) * 32'h0101_0101;
                    mask    = 32'hFF << (8 * a);
                end
                OP_SH: begin
                    r.be    = (a >= 2) ? 4'hC : 4'h3;
                    r.wdata = (rt & 32'hFFFF) * 32'h0001_0001;
                    mask    = 32'hFFFF << (16 * (a / 2));
                end
                default: begin
                    r.be    = 4'hF;
                    r.wdata = rt;
                    mask    = 32'hFFFF_FFFF;
                end
            endcase
            ref_mem[idx] = (w & ~mask) | (r.wdata & mask);
            req_q.push_back(r);
        end

        done_q.push_back(d);
        if (!(is_ld || is_st)) exp_stall = 0;
        else if (mis)          exp_stall = 1;
        else                   exp_stall = 2 + delay;

        finished  = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 64 && !finished; c++) begin
            @(negedge clk);
            if (!stall) finished = 1'b1;
            else stall_cnt++;
        end
        checkOutput("slot_complete", 32'(finished), 32'd1);
        if (!finished) begin
            printSummary();
        end else begin
            checkOutput("stall_cycles", stall_cnt, exp_stall);
            @(posedge clk);
            #1;
        end
    endtask

    // Memory responder: checks every request cycle against the expected request,
    // acks after ack_delay wait cycles and applies writes to its own memory image.
    initial begin
        int   wait_cnt;
        req_t r;
        wait_cnt  = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req) begin
                if (req_q.size() == 0) begin
                    checkOutput("spurious_req", req_q.size(), 1);
                end else begin
                    r = req_q[0];
                    checkOutput("req_we", 32'(mem_we), 32'(r.we));
                    checkOutput("req_addr", mem_addr, r.addr);
                    checkOutput("req_be", 32'(mem_be), 32'(r.be));
                    checkOutput("req_wdata", mem_wdata, r.wdata);
                    if (wait_cnt >= ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = bus_mem[mem_addr[5:2]];
                        if (mem_we) begin
                            for (int k = 0; k < 4; k++) begin
                                if (mem_be[k]) bus_mem[mem_addr[5:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                            end
                        end
                        void'(req_q.pop_front());
                        wait_cnt = 0;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                wait_cnt = 0;
                checkOutput("idle_be", 32'(mem_be), 32'h0);
                checkOutput("idle_wdata", mem_wdata, 32'h0);
                if (stray_ack) begin
                    mem_ack   = 1'b1;
                    stray_ack = 1'b0;
                end
            end
        end
    end

    // Monitor: every non-stalled cycle out of reset is one completed instruction slot.
    always @(negedge clk) begin
        done_t e;
        if (reset && !stall) begin
            if (done_q.size() == 0) begin
                checkOutput("done_q_size", done_q.size(), 1);
            end else begin
                e = done_q.pop_front();
                checkOutput("instr_out", instr_out, e.instr);
                checkOutput("pc4_out", pc4_out, e.pc4);
                checkOutput("alu_out", alu_out, e.alu);
                checkOutput("memdata_out", memdata_out, e.memdata);
                checkOutput("align_err", 32'(align_err), 32'(e.err));
            end
        end
    end

    task automatic abortTransaction();
        instr_m   = {OP_LW, 26'($urandom)};
        pc4_m     = $urandom;
        alu_m     = 32'h0000_0020;
        rt_m      = 32'h0;
        ack_delay = 50;
        req_q.push_back('{we: 1'b0, addr: 32'h0000_0020, be: 4'hF, wdata: 32'h0});
        repeat (3) @(negedge clk);
        checkOutput("abort_req_before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b0;
        req_q.delete();
        instr_m = 32'h0;
        @(negedge clk);
        checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
        checkOutput("abort_stall", 32'(stall), 32'd0);
        checkOutput("abort_memdata", memdata_out, 32'h0);
        checkOutput("abort_align_err", 32'(align_err), 32'd0);
        stray_ack = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] v;
`ifdef MEM_ALIGN_CHECK_EN
        align_chk = 1'b1;
`else
        align_chk = 1'b0;
`endif
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
                6'h00, 6'h22, 6'h2A, 6'h0F};
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            ref_mem[i] = v;
            bus_mem[i] = v;
        end
        ref_mem[4] = 32'hDEAD_BEEF;
        bus_mem[4] = 32'hDEAD_BEEF;
        ref_mem[5] = 32'h0080_FF00;
        bus_mem[5] = 32'h0080_FF00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_memdata", memdata_out, 32'h0);
        checkOutput("reset_align_err", 32'(align_err), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        applyStimulus(6'h00, 32'h0000_1234, $urandom, 0);
        applyStimulus(OP_LW, 32'h0000_0010, $urandom, 2);
        applyStimulus(OP_LB, 32'h0000_0016, $urandom, 0);
        applyStimulus(OP_LBU, 32'h0000_0016, $urandom, 1);
        applyStimulus(OP_SH, 32'h0000_001A, 32'h0000_ABCD, 0);
        applyStimulus(OP_LW, 32'h0000_0011, $urandom, 0);
        applyStimulus(OP_SW, 32'h0000_0013, $urandom, 1);
        applyStimulus(OP_LH, 32'h0000_0017, $urandom, 0);

        abortTransaction();
        applyStimulus(6'h00, $urandom, $urandom, 0);
        applyStimulus(6'h00, $urandom, $urandom, 0);

        for (int i = 0; i < 200; i++) begin
            applyStimulus(ops[$urandom_range(0, 11)], $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        applyStimulus(6'h00, $urandom, $urandom, 0);
        checkOutput("done_q_drained", done_q.size(), 0);
        checkOutput("req_q_drained", req_q.size(), 0);
        printSummary();
    end

endmodule
